mem_request_unit: RTL and testbench
===================================

MEM_REQUEST_UNIT -- requirements
Module: mem_request_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 nrst  in  1  asynchronous, active-low reset.
REQ-003 fetch_req  in  1  instruction fetch request.
REQ-004 pc  in  32  fetch byte address.
REQ-005 instr  out  32  fetched instruction.
REQ-006 instr_valid  out  1  instr valid this cycle.
REQ-007 dread, dwrite  in  1 each  data load/store request; held by requester until dack.
REQ-008 daddr  in  32  data byte address.
REQ-009 dwdata  in  32  store data, right-aligned.
REQ-010 dsize  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 drdata  out  32  load result, extended per dsize.
REQ-012 dack  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  data operation in progress (core stall).
REQ-014 derr  out  1  data request error, valid with dack.
REQ-015 ram_addr_data, ram_addr_instr  out  12  RAM word addresses.
REQ-016 ram_data_in  out  32  RAM write data; ram_we  out  1  RAM write enable.
REQ-017 ram_data_out, ram_instr_out  in  32  RAM registered read data; one-cycle read latency, read-before-write.

Function
REQ-018 States SHALL be IDLE, LD_ISSUE, LD_DONE, WR_COMMIT, RMW_ISSUE, RMW_MERGE, ERR.
REQ-019 IDLE SHALL sample a request on the rising edge; the address, data and size are registered at acceptance and the live inputs are ignored until return to IDLE.
REQ-020 Load: IDLE->LD_ISSUE (ram_addr_data=addr[13:2], ram_we=0)->LD_DONE (dack=1, drdata=lane-extracted ram_data_out)->IDLE.
REQ-021 Word store: IDLE->WR_COMMIT (ram_we=1, ram_data_in=wdata, dack=1)->IDLE.
REQ-022 Byte/half store: IDLE->RMW_ISSUE (read)->RMW_MERGE (ram_we=1, ram_data_in=ram_data_out with addressed lane(s) replaced, dack=1)->IDLE.
REQ-023 Error conditions SHALL be dread and dwrite both high, daddr[31:14]!=0, H/HU with daddr[0]=1, W with daddr[1:0]!=0, or an undefined dsize. Any of these SHALL take IDLE->ERR (dack=1, derr=1, drdata=0, no RAM write)->IDLE.
REQ-024 busy SHALL equal (state!=IDLE); dack and derr SHALL be 0 outside the states above.
REQ-025 Lane select SHALL use addr[1:0]. Byte lane n SHALL be bits 8n+7:8n. B/H SHALL sign-extend; BU/HU SHALL zero-extend.
REQ-026 ram_we SHALL be 1 only in WR_COMMIT and RMW_MERGE.
REQ-027 ram_addr_data SHALL hold the registered address in every state other than IDLE.
REQ-028 Fetch SHALL be independent of the data FSM: ram_addr_instr=pc[13:2] combinationally. instr_valid SHALL be fetch_req delayed one cycle. instr SHALL equal ram_instr_out.
REQ-029 Fetch and store to the same word in the same cycle SHALL return the pre-write word.
REQ-030 Back-to-back requests SHALL be accepted in the IDLE cycle following dack. There SHALL be no combinational path from dread/dwrite to dack.

Reset
REQ-031 nrst low SHALL immediately set: state=IDLE, ram_we=0, dack=0, derr=0, busy=0, instr_valid=0, drdata=0, all address/data registers=0.
REQ-032 Reset mid-operation SHALL abort the operation with no dack. A partial store aborted in RMW_ISSUE SHALL leave memory unchanged.

Structure
REQ-033 Package mem_pkg SHALL hold the state enum, dsize codes, RAM_AW=12 and the address-range constant.
REQ-034 Sub-module mem_lane_align (combinational) SHALL implement load extraction/extension and store lane merge.

Verification
REQ-035 Load word: preload word 3=0xDEADBEEF, LW daddr=0x0C -> dack two cycles after acceptance, drdata=0xDEADBEEF, derr=0.
REQ-036 Byte RMW store: word 3=0xDEADBEEF, SB daddr=0x0D dwdata=0x12 -> dack in RMW_MERGE, word 3=0xDEAD12EF; LB 0x0F -> 0xFFFFFFDE; LBU 0x0F -> 0x000000DE.
REQ-037 Errors: LW daddr=0x02 -> derr=1, drdata=0, no write. SH daddr=0x4001 -> derr=1. dread=dwrite=1 -> derr=1.
REQ-038 Concurrency: fetch pc=0x10 while SW daddr=0x10 dwdata=0x1 onto old value 0x5 -> instr=0x5 next cycle, subsequent LW returns 0x1.
REQ-039 Reset: assert nrst in RMW_ISSUE of SH 0x20 -> ram_we=0 immediately, no dack, word 8 unchanged, busy=0.
REQ-040 Throughput: three back-to-back LW requests -> exactly three dack pulses, busy low exactly one cycle between operations.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory request unit: FSM states, RV32I
// access-size codes, RAM geometry and the request error check.
package mem_pkg;

    // RAM word-address width; the RAM covers byte addresses [0, 2**ADDR_BITS).
    localparam int unsigned RAM_AW    = 12;
    localparam int unsigned ADDR_BITS = RAM_AW + 2;

    // dsize encodings (RV32I load/store funct3)
    localparam logic [2:0] SizeB  = 3'b000;
    localparam logic [2:0] SizeH  = 3'b001;
    localparam logic [2:0] SizeW  = 3'b010;
    localparam logic [2:0] SizeBu = 3'b100;
    localparam logic [2:0] SizeHu = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StLdIssue,
        StLdDone,
        StWrCommit,
        StRmwIssue,
        StRmwMerge,
        StErr
    } mem_state_e;

    // True when a data request must be rejected instead of touching the RAM.
    function automatic logic req_error(input logic        rd,
                                       input logic        wr,
                                       input logic [31:0] addr,
                                       input logic [2:0]  size);
        logic err;
        err = rd && wr;
        if (addr[31:ADDR_BITS] != '0) begin
            err = 1'b1;
        end
        unique case (size)
            SizeB, SizeBu: ;
            SizeH, SizeHu: if (addr[0]) err = 1'b1;
            SizeW:         if (addr[1:0] != 2'b00) err = 1'b1;
            default:       err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_request_unit_if.sv
// Core-side fetch/data request bus plus the RAM port of the memory request unit.
interface mem_request_unit_if
    import mem_pkg::*;
();
    // instruction fetch
    logic              fetch_req;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              instr_valid;
    // data request
    logic              dread;
    logic              dwrite;
    logic [31:0]       daddr;
    logic [31:0]       dwdata;
    logic [2:0]        dsize;
    logic [31:0]       drdata;
    logic              dack;
    logic              busy;
    logic              derr;
    // RAM port (registered read, read-before-write)
    logic [RAM_AW-1:0] ram_addr_data;
    logic [RAM_AW-1:0] ram_addr_instr;
    logic [31:0]       ram_data_in;
    logic              ram_we;
    logic [31:0]       ram_data_out;
    logic [31:0]       ram_instr_out;

    // Memory request unit side
    modport slave (
        input  fetch_req, pc, dread, dwrite, daddr, dwdata, dsize,
        input  ram_data_out, ram_instr_out,
        output instr, instr_valid, drdata, dack, busy, derr,
        output ram_addr_data, ram_addr_instr, ram_data_in, ram_we
    );

    // Core plus RAM side
    modport master (
        output fetch_req, pc, dread, dwrite, daddr, dwdata, dsize,
        output ram_data_out, ram_instr_out,
        input  instr, instr_valid, drdata, dack, busy, derr,
        input  ram_addr_data, ram_addr_instr, ram_data_in, ram_we
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extracts and extends a load from a RAM word, and merges
// store data into the addressed lane(s) of a RAM word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load path: pick the lane then sign- or zero-extend.
    always_comb begin
        byte_sel    = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel    = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        load_data_o = rdata_i;
        unique case (size_i)
            SizeB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
            SizeH:   load_data_o = {{16{half_sel[15]}}, half_sel};
            SizeBu:  load_data_o = {24'h0, byte_sel};
            SizeHu:  load_data_o = {16'h0, half_sel};
            default: load_data_o = rdata_i;
        endcase
    end

    // Store path: stores only use the width bits, so BU/HU codes act as B/H.
    always_comb begin
        store_data_o = rdata_i;
        unique case (size_i[1:0])
            2'b00:   store_data_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
            2'b01:   store_data_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: store_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_request_unit.sv
// Memory request unit: independent instruction fetch path plus a data FSM that
// performs loads, word stores, read-modify-write sub-word stores and rejects
// illegal requests against a single-port-per-path synchronous RAM.
module mem_request_unit
    import mem_pkg::*;
(
    input logic               clk,
    input logic               nrst,
    mem_request_unit_if.slave bus
);

    mem_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [2:0]           size_q, size_d;
    logic                 instr_valid_q;

    logic [31:0]          load_data;
    logic [31:0]          store_data;
    logic                 unused_pc;

    // Only the word index of pc reaches the RAM.
    assign unused_pc = ^{bus.pc[31:ADDR_BITS], bus.pc[1:0]};

    // State, captured request and fetch-valid registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            size_q        <= size_d;
            instr_valid_q <= bus.fetch_req;
        end
    end

    // Next state: capture the request in idle, then walk the fixed sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        unique case (state_q)
            StIdle: begin
                if (bus.dread || bus.dwrite) begin
                    addr_d  = bus.daddr[ADDR_BITS-1:0];
                    wdata_d = bus.dwdata;
                    size_d  = bus.dsize;
                    if (req_error(bus.dread, bus.dwrite, bus.daddr, bus.dsize)) begin
                        state_d = StErr;
                    end else if (bus.dread) begin
                        state_d = StLdIssue;
                    end else if (bus.dsize[1:0] == SizeW[1:0]) begin
                        state_d = StWrCommit;
                    end else begin
                        state_d = StRmwIssue;
                    end
                end
            end
            StLdIssue:  state_d = StLdDone;
            StRmwIssue: state_d = StRmwMerge;
            StLdDone, StWrCommit, StRmwMerge, StErr: state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    mem_lane_align u_lane_align (
        .rdata_i      (bus.ram_data_out),
        .wdata_i      (wdata_q),
        .offset_i     (addr_q[1:0]),
        .size_i       (size_q),
        .load_data_o  (load_data),
        .store_data_o (store_data)
    );

    // Outputs decoded from state only, so dread/dwrite never reach dack combinationally.
    always_comb begin
        bus.dack          = 1'b0;
        bus.derr          = 1'b0;
        bus.ram_we        = 1'b0;
        bus.drdata        = '0;
        bus.busy          = (state_q != StIdle);
        bus.ram_addr_data = addr_q[ADDR_BITS-1:2];
        bus.ram_data_in   = store_data;
        unique case (state_q)
            StLdDone: begin
                bus.dack   = 1'b1;
                bus.drdata = load_data;
            end
            StWrCommit, StRmwMerge: begin
                bus.dack   = 1'b1;
                bus.ram_we = 1'b1;
            end
            StErr: begin
                bus.dack = 1'b1;
                bus.derr = 1'b1;
            end
            default: ;
        endcase
    end

    // Fetch path runs alongside the data FSM.
    always_comb begin
        bus.ram_addr_instr = bus.pc[ADDR_BITS-1:2];
        bus.instr          = bus.ram_instr_out;
        bus.instr_valid    = instr_valid_q;
    end

endmodule

// File: tb/tb_mem_request_unit.sv
// Self-checking bench for mem_request_unit: directed vector table, multi-cycle
// corner sequences and random traffic against a byte-level memory model.
module tb_mem_request_unit;
    import mem_pkg::*;

    logic clk;
    logic nrst;

    mem_request_unit_if bus ();

    mem_request_unit dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: registered reads, read-before-write, plus a backdoor port.
    logic [31:0] ram [0:4095] = '{default: '0};
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        bus.ram_data_out  <= ram[bus.ram_addr_data];
        bus.ram_instr_out <= ram[bus.ram_addr_instr];
        if (bus.ram_we) ram[bus.ram_addr_data] <= bus.ram_data_in;
        else if (bd_we) ram[bd_addr] <= bd_data;
    end

    // Reference model: flat little-endian byte memory.
    logic [7:0] mb [0:16383] = '{default: '0};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_op(input logic rd, input logic wr, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [2:0] sz,
                                     output logic err, output logic [31:0] rdat,
                                     output int lat);
        int   n;
        logic sgn;
        err  = 1'b0;
        rdat = '0;
        n    = 1;
        sgn  = 1'b0;
        case (sz)
            3'b000:  begin n = 1; sgn = 1'b1; end
            3'b001:  begin n = 2; sgn = 1'b1; end
            3'b010:  n = 4;
            3'b100:  n = 1;
            3'b101:  n = 2;
            default: err = 1'b1;
        endcase
        if (rd && wr) err = 1'b1;
        if (a >= 32'h4000) err = 1'b1;
        if ((a % n) != 0) err = 1'b1;
        if (err) begin
            lat = 1;
        end else if (rd) begin
            lat = 2;
            for (int i = 0; i < n; i++) rdat = rdat | (32'(mb[a + i]) << (8 * i));
            if (sgn && n == 1 && rdat[7]) rdat = rdat | 32'hFFFF_FF00;
            if (sgn && n == 2 && rdat[15]) rdat = rdat | 32'hFFFF_0000;
        end else begin
            lat = (n == 4) ? 1 : 2;
            for (int i = 0; i < n; i++) mb[a + i] = wd[8 * i +: 8];
        end
    endfunction

    task automatic preload(input logic [11:0] widx, input logic [31:0] data);
        bd_we   = 1'b1;
        bd_addr = widx;
        bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
        for (int i = 0; i < 4; i++) mb[{widx, 2'b00} + i] = data[8 * i +: 8];
    endtask

    // Issue one request from an idle negedge; returns at the following idle negedge.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] sz,
                         output logic [31:0] rdat, output logic err, output int lat);
        logic got;
        bus.dread  = rd;
        bus.dwrite = wr;
        bus.daddr  = a;
        bus.dwdata = wd;
        bus.dsize  = sz;
        got  = 1'b0;
        lat  = 0;
        rdat = '0;
        err  = 1'b0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.dack) begin
                got  = 1'b1;
                rdat = bus.drdata;
                err  = bus.derr;
            end
        end
        bus.dread  = 1'b0;
        bus.dwrite = 1'b0;
        if (!got) check("dack_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("dack_pulse_busy", {bus.dack, bus.busy}, 2'b00);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] sz,
                                input logic e, input logic [31:0] r, input int l);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.size = sz;
        v.exp_err = e; v.exp_rdata = r; v.exp_lat = l;
        return v;
    endfunction

    vec_t        vecs [16];
    logic [31:0] rdat, mrdat;
    logic        err, merr;
    int          lat, mlat;
    int          dacks;
    logic [10:0] busy_seen;

    initial begin
        nrst          = 1'b0;
        bd_we         = 1'b0;
        bd_addr       = '0;
        bd_data       = '0;
        bus.fetch_req = 1'b0;
        bus.pc        = '0;
        bus.dread     = 1'b0;
        bus.dwrite    = 1'b0;
        bus.daddr     = '0;
        bus.dwdata    = '0;
        bus.dsize     = '0;

        vecs[0]  = mk(1, 0, 32'h0C,   32'h0,        SizeW,  0, 32'hDEADBEEF, 2);
        vecs[1]  = mk(0, 1, 32'h0D,   32'h12,       SizeB,  0, 32'h0,        2);
        vecs[2]  = mk(1, 0, 32'h0C,   32'h0,        SizeW,  0, 32'hDEAD12EF, 2);
        vecs[3]  = mk(1, 0, 32'h0F,   32'h0,        SizeB,  0, 32'hFFFFFFDE, 2);
        vecs[4]  = mk(1, 0, 32'h0F,   32'h0,        SizeBu, 0, 32'h000000DE, 2);
        vecs[5]  = mk(1, 0, 32'h0E,   32'h0,        SizeH,  0, 32'hFFFFDEAD, 2);
        vecs[6]  = mk(1, 0, 32'h0E,   32'h0,        SizeHu, 0, 32'h0000DEAD, 2);
        vecs[7]  = mk(1, 0, 32'h0C,   32'h0,        SizeH,  0, 32'h000012EF, 2);
        vecs[8]  = mk(1, 0, 32'h0C,   32'h0,        SizeB,  0, 32'hFFFFFFEF, 2);
        vecs[9]  = mk(1, 0, 32'h02,   32'h0,        SizeW,  1, 32'h0,        1);
        vecs[10] = mk(0, 1, 32'h4001, 32'hBEEF,     SizeH,  1, 32'h0,        1);
        vecs[11] = mk(1, 1, 32'h0C,   32'h0,        SizeW,  1, 32'h0,        1);
        vecs[12] = mk(1, 0, 32'h0C,   32'h0,        3'b011, 1, 32'h0,        1);
        vecs[13] = mk(0, 1, 32'h0D,   32'hFFFFFFFF, SizeW,  1, 32'h0,        1);
        vecs[14] = mk(1, 0, 32'h0C,   32'h0,        SizeW,  0, 32'hDEAD12EF, 2);
        vecs[15] = mk(1, 0, 32'h00,   32'h0,        SizeW,  0, 32'h00000000, 2);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flags", {bus.busy, bus.dack, bus.derr, bus.ram_we, bus.instr_valid}, 5'b0);
        check("rst_drdata", bus.drdata, 32'h0);
        check("rst_addr", 32'(bus.ram_addr_data), 32'h0);
        nrst = 1'b1;
        @(negedge clk);

        // Directed vector table
        preload(12'd3, 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                  rdat, err, lat);
            model_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size,
                     merr, mrdat, mlat);
            check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
            check($sformatf("vec%0d_derr", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end
        check("word0_after_errors", ram[0], 32'h0);

        // Fetch and store to the same word in the same cycle
        preload(12'd4, 32'h5);
        bus.fetch_req = 1'b1;
        bus.pc        = 32'h10;
        bus.dwrite    = 1'b1;
        bus.daddr     = 32'h10;
        bus.dwdata    = 32'h1;
        bus.dsize     = SizeW;
        @(negedge clk);
        check("conc_commit", {bus.dack, bus.ram_we, bus.derr}, 3'b110);
        bus.dwrite = 1'b0;
        @(negedge clk);
        check("conc_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("conc_instr", bus.instr, 32'h5);
        bus.fetch_req = 1'b0;
        @(negedge clk);
        check("conc_instr_valid_drop", 32'(bus.instr_valid), 32'd0);
        model_op(0, 1, 32'h10, 32'h1, SizeW, merr, mrdat, mlat);
        do_op(1, 0, 32'h10, 32'h0, SizeW, rdat, err, lat);
        check("conc_reload", rdat, 32'h1);

        // Reset while a half-word store sits in its read phase
        preload(12'd8, 32'hA5A55A5A);
        bus.dwrite = 1'b1;
        bus.daddr  = 32'h20;
        bus.dwdata = 32'hBEEF;
        bus.dsize  = SizeH;
        @(negedge clk);
        check("rmw_issue_busy", {bus.busy, bus.ram_we, bus.dack}, 3'b100);
        nrst = 1'b0;
        #1;
        check("rst_mid_flags", {bus.busy, bus.ram_we, bus.dack}, 3'b000);
        bus.dwrite = 1'b0;
        dacks = 0;
        @(negedge clk);
        dacks += 32'(bus.dack);
        @(negedge clk);
        dacks += 32'(bus.dack);
        nrst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            dacks += 32'(bus.dack);
        end
        check("rst_mid_no_dack", dacks, 0);
        check("rst_mid_word8", ram[8], 32'hA5A55A5A);
        do_op(1, 0, 32'h20, 32'h0, SizeW, rdat, err, lat);
        check("rst_mid_reload", rdat, 32'hA5A55A5A);

        // Three back-to-back word loads with the request held high
        model_op(1, 0, 32'h0C, 32'h0, SizeW, merr, mrdat, mlat);
        dacks      = 0;
        bus.dread  = 1'b1;
        bus.daddr  = 32'h0C;
        bus.dsize  = SizeW;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) @(negedge clk);
            busy_seen[i] = bus.busy;
            if (bus.dack) begin
                dacks++;
                check($sformatf("tp_drdata%0d", dacks), bus.drdata, mrdat);
            end
            if (dacks == 3) bus.dread = 1'b0;
        end
        bus.dread = 1'b0;
        check("tp_dack_count", dacks, 3);
        check("tp_busy_pattern", 32'(busy_seen), 32'(11'b00110110110));
        repeat (3) @(negedge clk);

        // Random traffic against the byte model
        for (int i = 0; i < 200; i++) begin
            logic        rd, wr;
            logic [31:0] a, wd;
            logic [2:0]  sz;
            int          r;
            r  = $urandom_range(0, 9);
            rd = (r <= 5);
            wr = (r == 0) || (r > 5);
            case ($urandom_range(0, 5))
                0:       sz = SizeB;
                1:       sz = SizeH;
                2:       sz = SizeW;
                3:       sz = SizeBu;
                4:       sz = SizeHu;
                default: sz = 3'($urandom_range(0, 7));
            endcase
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) < 7) begin
                if (sz[1:0] == 2'b01) a[0] = 1'b0;
                if (sz[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 19) == 0) a = a | (32'($urandom_range(1, 255)) << 14);
            wd = $urandom;
            do_op(rd, wr, a, wd, sz, rdat, err, lat);
            model_op(rd, wr, a, wd, sz, merr, mrdat, mlat);
            check($sformatf("rand%0d_rdata", i), rdat, mrdat);
            check($sformatf("rand%0d_derr", i), 32'(err), 32'(merr));
            check($sformatf("rand%0d_latency", i), lat, mlat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
